// File: rtl/serial_subtractor_if.sv
// Valid/ready operand and result bundle for the bit-serial subtractor.
// The master drives operands and out_ready; the slave returns the result.
interface serial_subtractor_if #(
    parameter int BITS = 8
);
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic            bin;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] diff;
    logic            bout;
    logic            ovf;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output a, b, bin, in_valid, out_ready,
        input  in_ready, diff, bout, ovf, out_valid
    );

    modport slave (
        input  a, b, bin, in_valid, out_ready,
        output in_ready, diff, bout, ovf, out_valid
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: one full-subtractor cell and a borrow
// flop compute a - b - bin LSB first over BITS cycles behind valid/ready.
module serial_subtractor #(
    parameter int BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);
    localparam logic [CW-1:0] PEN  = CW'(BITS - 2);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_n;
    logic [BITS-1:0] a_sh, b_sh, diff_q;
    logic [CW-1:0]   cnt;
    logic            br, msb_bin, bout_q, ovf_q;
    logic            ai, bi, d, br_n;

    assign ai   = a_sh[0];
    assign bi   = b_sh[0];
    assign d    = ai ^ bi ^ br;
    assign br_n = (~ai & bi) | (~(ai ^ bi) & br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (bus.in_valid)  state_n = BUSY;
            BUSY: if (cnt == LAST)   state_n = DONE;
            DONE: if (bus.out_ready) state_n = IDLE;
            default:                 state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_q  <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            msb_bin <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_sh <= bus.a;
                    b_sh <= bus.b;
                    br   <= bus.bin;
                    cnt  <= '0;
                end
                BUSY: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_n;
                    // Result enters at the MSB so bit 0 lands at diff[0] after BITS shifts
                    diff_q <= {d, diff_q[BITS-1:1]};
                    if (cnt == PEN) msb_bin <= br_n;
                    if (cnt == LAST) begin
                        bout_q <= br_n;
                        ovf_q  <= msb_bin ^ br_n;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at BITS=8 and BITS=3.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.BITS(8)) s8 ();
    serial_subtractor_if #(.BITS(3)) s3 ();

    serial_subtractor #(.BITS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(s8));
    serial_subtractor #(.BITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(s3));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent arithmetic model: integer subtraction, signed range test for overflow
    task automatic ref_model(input int w, input int a, input int b, input int bin,
                             output int d, output int bo, output int ov);
        int full, sa, sb, sr, half;
        half = 1 << (w - 1);
        full = a - b - bin;
        d    = full & ((1 << w) - 1);
        bo   = (full < 0) ? 1 : 0;
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        sr   = sa - sb - bin;
        ov   = (sr >= half || sr < -half) ? 1 : 0;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input int stall, input bit toggle,
                       output logic [7:0] d, output logic bo, output logic ov, output int lat);
        int t;
        t = 0;
        while (!s8.in_ready && t < 20) begin @(negedge clk); t++; end
        if (!s8.in_ready) chk("in_ready_timeout8", 32'(s8.in_ready), 32'd1);
        s8.a = a; s8.b = b; s8.bin = bin; s8.in_valid = 1'b1;
        @(negedge clk);
        s8.in_valid = 1'b0;
        lat = 0;
        while (!s8.out_valid && lat < 40) begin @(negedge clk); lat++; end
        d = s8.diff; bo = s8.bout; ov = s8.ovf;
        for (int i = 0; i < stall; i++) begin
            if (toggle) begin
                s8.a = 8'($urandom); s8.b = 8'($urandom); s8.bin = 1'($urandom);
                s8.in_valid = ~s8.in_valid;
            end
            @(negedge clk);
            chk("hold8", {s8.diff, s8.bout, s8.ovf, s8.out_valid, s8.in_ready},
                {d, bo, ov, 1'b1, 1'b0});
        end
        s8.in_valid  = 1'b0;
        s8.out_ready = 1'b1;
        @(negedge clk);
        s8.out_ready = 1'b0;
        chk("post_hs8", {s8.out_valid, s8.in_ready}, 2'b01);
    endtask

    task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic bin, input int stall,
                       output logic [2:0] d, output logic bo, output logic ov, output int lat);
        s3.a = a; s3.b = b; s3.bin = bin; s3.in_valid = 1'b1;
        @(negedge clk);
        s3.in_valid = 1'b0;
        lat = 0;
        while (!s3.out_valid && lat < 20) begin @(negedge clk); lat++; end
        d = s3.diff; bo = s3.bout; ov = s3.ovf;
        repeat (stall) @(negedge clk);
        chk("hold3", {s3.diff, s3.bout, s3.ovf, s3.out_valid}, {d, bo, ov, 1'b1});
        s3.out_ready = 1'b1;
        @(negedge clk);
        s3.out_ready = 1'b0;
        chk("post_hs3", {s3.out_valid, s3.in_ready}, 2'b01);
    endtask

    initial begin
        logic [7:0] d8;
        logic [2:0] d3;
        logic       bo, ov;
        int         lat, ed, eb, eo, ra, rb, rc;

        vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[1] = '{8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0};

        s8.a = '0; s8.b = '0; s8.bin = 1'b0; s8.in_valid = 1'b0; s8.out_ready = 1'b0;
        s3.a = '0; s3.b = '0; s3.bin = 1'b0; s3.in_valid = 1'b0; s3.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_state", {s8.diff, s8.bout, s8.ovf, s8.out_valid}, 11'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(s8.in_ready), 32'd1);

        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, 0, 1'b0, d8, bo, ov, lat);
            chk($sformatf("vec%0d_diff", i), 32'(d8), 32'(vecs[i].diff));
            chk($sformatf("vec%0d_flags", i), {bo, ov}, {vecs[i].bout, vecs[i].ovf});
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
        end

        // Backpressure with operand and in_valid churn while holding DONE
        op8(8'h20, 8'h50, 1'b0, 5, 1'b1, d8, bo, ov, lat);
        chk("bp_result", {d8, bo, ov}, {8'hD0, 1'b1, 1'b0});

        // Asynchronous reset in the middle of BUSY
        s8.a = 8'h50; s8.b = 8'h20; s8.bin = 1'b0; s8.in_valid = 1'b1;
        @(negedge clk);
        s8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {s8.in_ready, s8.out_valid}, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_clear", {s8.diff, s8.bout, s8.ovf, s8.out_valid}, 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_midreset", {s8.in_ready, s8.out_valid}, 2'b10);
        op8(8'h50, 8'h20, 1'b0, 0, 1'b0, d8, bo, ov, lat);
        chk("post_reset_result", {d8, bo, ov}, {8'h30, 1'b0, 1'b0});
        chk("post_reset_latency", 32'(lat), 32'd8);

        for (int n = 0; n < 1000; n++) begin
            ra = int'($urandom_range(0, 255)); rb = int'($urandom_range(0, 255));
            rc = int'($urandom_range(0, 1));
            op8(8'(ra), 8'(rb), 1'(rc), int'($urandom_range(0, 3)), 1'b0, d8, bo, ov, lat);
            ref_model(8, ra, rb, rc, ed, eb, eo);
            chk("rand8", {lat[7:0], d8, bo, ov}, {8'd8, 8'(ed), 1'(eb), 1'(eo)});
        end

        for (int n = 0; n < 1000; n++) begin
            ra = int'($urandom_range(0, 7)); rb = int'($urandom_range(0, 7));
            rc = int'($urandom_range(0, 1));
            op3(3'(ra), 3'(rb), 1'(rc), int'($urandom_range(0, 3)), d3, bo, ov, lat);
            ref_model(3, ra, rb, rc, ed, eb, eo);
            chk("rand3", {lat[7:0], d3, bo, ov}, {8'd3, 3'(ed), 1'(eb), 1'(eo)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
